// File: rtl/sh_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : sh_bus_arb
// Brief    : External-bus arbiter sharing the SH7604 master's bus among up to
//            four secondary masters. Requests release from the master
//            (BRLS_N), waits for its grant (BGR_N), hands the bus to one
//            requester at a time in round-robin order, then returns it and
//            enforces a minimum master hold gap before the next release.
// Options  : SH_BUS_ARB_WDOG_EN - enables the per-grant hold watchdog
//            (HOLD_MAX) and the sticky TIMEOUT flag.
// Revision : 1.0 - initial release
// ============================================================================
module sh_bus_arb #(
    parameter int NREQ       = 2,
    parameter int MASTER_GAP = 4,
    parameter int HOLD_MAX   = 255
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE_R,
    input  logic [NREQ-1:0] REQ_N,
    output logic [NREQ-1:0] ACK_N,
    output logic            BRLS_N,
    input  logic            BGR_N,
    output logic [2:0]      OWNER,
    output logic            TIMEOUT
);

    // Gap counter must hold MASTER_GAP; keep at least one bit when it is 0.
    localparam int              c_gap_w    = (MASTER_GAP > 0) ? $clog2(MASTER_GAP + 1) : 1;
    localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(MASTER_GAP);
    localparam logic [2:0]      c_last_idx = 3'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RELREQ = 3'd1,
        S_GRANT  = 3'd2,
        S_RETURN = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_sel;
    logic [2:0]           w_sel_nxt;
    logic [NREQ-1:0]      r_sel_oh;
    logic [NREQ-1:0]      w_sel_oh_nxt;
    logic [2:0]           r_ptr;
    logic [2:0]           w_ptr_nxt;
    logic [c_gap_w-1:0]   r_gap_cnt;
    logic [c_gap_w-1:0]   w_gap_cnt_nxt;

    logic [NREQ-1:0]      r_ack_n;
    logic [NREQ-1:0]      w_ack_n_nxt;
    logic                 r_brls_n;
    logic                 w_brls_n_nxt;
    logic [2:0]           r_owner;
    logic [2:0]           w_owner_nxt;

    // Requests eligible for arbitration (watchdog may mask some).
    logic [NREQ-1:0]      w_req;
    // Selected requester still holding its request low.
    logic                 w_sel_req;
    logic [2:0]           w_win;
    logic [NREQ-1:0]      w_win_oh;
    logic                 w_win_vld;

    assign w_sel_req = |(~REQ_N & r_sel_oh);

`ifdef SH_BUS_ARB_WDOG_EN
    localparam int                  c_hold_w    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_MAX - 1);

    logic [c_hold_w-1:0] r_hold_cnt;
    logic [NREQ-1:0]     r_blocked;
    logic                r_timeout;
    logic                w_hold_expired;
    logic                w_wdog_fire;

    // A requester cut off by the watchdog stays out until it lets go of REQ_N.
    assign w_req          = ~REQ_N & ~r_blocked;
    assign w_hold_expired = (r_hold_cnt == c_hold_last);
    assign TIMEOUT        = r_timeout;

    // Hold counter, blocked mask and sticky timeout flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold_cnt <= '0;
            r_blocked  <= '0;
            r_timeout  <= 1'b0;
        end else if (CE_R) begin
            if (r_state == S_GRANT) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end
            if (w_wdog_fire) begin
                r_timeout <= 1'b1;
            end
            r_blocked <= (r_blocked & ~REQ_N) | (w_wdog_fire ? r_sel_oh : '0);
        end
    end
`else
    localparam int c_unused_hold_max = HOLD_MAX;

    assign w_req   = ~REQ_N;
    assign TIMEOUT = 1'b0;
`endif

    // Round-robin winner: lowest active index at or above PTR, else lowest overall.
    always_comb begin
        w_win     = 3'd0;
        w_win_vld = 1'b0;
        w_win_oh  = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_req[j]) begin
                w_win     = 3'(j);
                w_win_vld = 1'b1;
            end
        end
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_req[j] && (j >= int'(r_ptr))) begin
                w_win = 3'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            w_win_oh[j] = (w_win == 3'(j));
        end
    end

    // Next-state logic; registered outputs are decoded from the next state.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_sel_oh_nxt  = r_sel_oh;
        w_ptr_nxt     = r_ptr;
        w_gap_cnt_nxt = r_gap_cnt;
`ifdef SH_BUS_ARB_WDOG_EN
        w_wdog_fire   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt  = S_RELREQ;
                    w_sel_nxt    = w_win;
                    w_sel_oh_nxt = w_win_oh;
                end
            end
            S_RELREQ: begin
                // A requester that gives up before the grant is never acked,
                // even if the master grants in the same cycle.
                if (!w_sel_req) begin
                    w_state_nxt = S_RETURN;
                end else if (!BGR_N) begin
                    w_state_nxt = S_GRANT;
                    w_ptr_nxt   = (r_sel == c_last_idx) ? 3'd0 : r_sel + 3'd1;
                end
            end
            S_GRANT: begin
                if (!w_sel_req) begin
                    w_state_nxt = S_RETURN;
`ifdef SH_BUS_ARB_WDOG_EN
                end else if (w_hold_expired) begin
                    w_state_nxt = S_RETURN;
                    w_wdog_fire = 1'b1;
`endif
                end
            end
            S_RETURN: begin
                if (BGR_N) begin
                    if (MASTER_GAP == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt   = S_GAP;
                        w_gap_cnt_nxt = c_gap_load;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_ack_n_nxt  = '1;
        w_brls_n_nxt = 1'b1;
        w_owner_nxt  = 3'd0;
        case (w_state_nxt)
            S_RELREQ: begin
                w_brls_n_nxt = 1'b0;
            end
            S_GRANT: begin
                w_brls_n_nxt = 1'b0;
                w_ack_n_nxt  = ~w_sel_oh_nxt;
                w_owner_nxt  = w_sel_nxt + 3'd1;
            end
            default: begin
                w_brls_n_nxt = 1'b1;
            end
        endcase
    end

    // State, selection, pointer, gap counter and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_sel     <= 3'd0;
            r_sel_oh  <= '0;
            r_ptr     <= 3'd0;
            r_gap_cnt <= '0;
            r_ack_n   <= '1;
            r_brls_n  <= 1'b1;
            r_owner   <= 3'd0;
        end else if (CE_R) begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_sel_oh  <= w_sel_oh_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_ack_n   <= w_ack_n_nxt;
            r_brls_n  <= w_brls_n_nxt;
            r_owner   <= w_owner_nxt;
        end
    end

    assign ACK_N  = r_ack_n;
    assign BRLS_N = r_brls_n;
    assign OWNER  = r_owner;

endmodule
`default_nettype wire
